// File: rtl/solar_display_scanner.sv
//------------------------------------------------------------------------------
// Module      : solar_display_scanner
// Description : Cycles a 5-to-1 display mux through its channels (voltage,
//               current, power, temperature, efficiency). For each channel it
//               waits for the registered mux output to settle, captures one
//               12-bit reading and shifts out a 16-bit frame
//               {1'b1, select[2:0], reading[11:0]} MSB first on a simple
//               chip-select / clock / data serial link. It then idles for a
//               programmable dwell time before moving to the next channel.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   SCLK_DIV   : half-period of frame_sclk in clk cycles (1..255)
//   DWELL      : idle clk cycles between frames (1..65535)
// Ports
//   clk        : in  1  single clock, rising edge
//   rst_n      : in  1  asynchronous active-low reset
//   enable     : in  1  level; scanning runs while high
//   hold       : in  1  level; keep the current channel after dwell
//   select     : out 3  channel select to the upstream display mux
//   mux_in     : in  12 registered mux output, valid 1 cycle after select
//   frame_cs_n : out 1  serial frame chip-select, active low
//   frame_sclk : out 1  serial clock
//   frame_sdo  : out 1  serial data, MSB first
//   frame_done : out 1  one-cycle pulse on the last cycle of each frame
//   busy       : out 1  high whenever the scanner is not idle
//------------------------------------------------------------------------------

`default_nettype none

module solar_display_scanner #(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned DWELL    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        hold,
  output logic [2:0]  select,
  input  logic [11:0] mux_in,
  output logic        frame_cs_n,
  output logic        frame_sclk,
  output logic        frame_sdo,
  output logic        frame_done,
  output logic        busy
);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_DWELL   = 3'd4;

  // Channel numbering of the upstream mux; the last one wraps back to 0.
  localparam logic [2:0] LAST_CHANNEL = 3'd4;

  // One serial bit spans 2*SCLK_DIV clocks: phase 0..SCLK_DIV-1 is the low
  // half of frame_sclk, SCLK_DIV..2*SCLK_DIV-1 the high half. 9 bits covers
  // the largest legal SCLK_DIV (2*255-1 = 509).
  localparam logic [8:0]  PHASE_HIGH = 9'(SCLK_DIV);
  localparam logic [8:0]  PHASE_LAST = 9'(2 * SCLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST   = 4'd15;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  logic [2:0]  state;
  logic        settle_cnt;   // two SETTLE cycles: 0 then 1
  logic [8:0]  phase_cnt;    // position inside the current serial bit
  logic [3:0]  bit_cnt;      // index of the serial bit being sent (0 = MSB)
  logic [15:0] dwell_cnt;    // cycles spent in DWELL so far
  logic [15:0] shreg;        // frame being shifted, MSB on the wire
  logic [2:0]  select_r;

  logic in_shift;
  logic bit_end;
  logic dwell_end;

  assign in_shift  = (state == ST_SHIFT);
  assign bit_end   = (phase_cnt == PHASE_LAST);
  assign dwell_end = (dwell_cnt == DWELL_LAST);

  //--------------------------------------------------------------------------
  // Sequencer
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 1'b0;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      dwell_cnt  <= '0;
      shreg      <= '0;
      select_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          settle_cnt <= 1'b0;
          if (enable) begin
            state <= ST_SETTLE;
          end
        end

        // The mux output is registered, so after select moves it takes one
        // cycle to become valid; the second cycle is margin.
        ST_SETTLE: begin
          if (settle_cnt) begin
            settle_cnt <= 1'b0;
            state      <= ST_CAPTURE;
          end else begin
            settle_cnt <= 1'b1;
          end
        end

        // The reading is frozen here; mux_in is ignored for the rest of the
        // frame.
        ST_CAPTURE: begin
          shreg     <= {1'b1, select_r, mux_in};
          phase_cnt <= '0;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (bit_end) begin
            phase_cnt <= '0;
            shreg     <= {shreg[14:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt   <= '0;
              dwell_cnt <= '0;
              state     <= ST_DWELL;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            phase_cnt <= phase_cnt + 9'd1;
          end
        end

        // enable and hold are only looked at here, so a frame that has
        // started always completes regardless of enable.
        ST_DWELL: begin
          if (dwell_end) begin
            dwell_cnt <= '0;
            if (enable) begin
              state <= ST_SETTLE;
              if (!hold) begin
                select_r <= (select_r >= LAST_CHANNEL) ? 3'd0
                                                       : select_r + 3'd1;
              end
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  // All serial outputs are decoded from registered state and gated by
  // in_shift, so the asynchronous reset forces them idle immediately and
  // they return to idle on the first cycle after SHIFT.
  assign select     = select_r;
  assign frame_cs_n = ~in_shift;
  assign frame_sclk = in_shift & (phase_cnt >= PHASE_HIGH);
  assign frame_sdo  = in_shift & shreg[15];
  assign frame_done = in_shift & bit_end & (bit_cnt == BIT_LAST);
  assign busy       = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_solar_display_scanner.sv
//------------------------------------------------------------------------------
// Module      : tb_solar_display_scanner
// Description : Self-checking bench for solar_display_scanner. An upstream
//               mux model feeds per-channel readings, a wire monitor decodes
//               every serial frame, and a channel-sequence model predicts
//               which channel and reading each frame must carry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`default_nettype none

module tb_solar_display_scanner;

  localparam int SCLK_DIV  = 2;
  localparam int DWELL_CYC = 4;
  localparam int BIT_CYC   = 2 * SCLK_DIV;
  localparam int FRAME_CYC = 16 * BIT_CYC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        hold;
  logic [2:0]  select;
  logic [11:0] mux_in;
  logic        frame_cs_n;
  logic        frame_sclk;
  logic        frame_sdo;
  logic        frame_done;
  logic        busy;

  solar_display_scanner #(
    .SCLK_DIV (SCLK_DIV),
    .DWELL    (DWELL_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .hold       (hold),
    .select     (select),
    .mux_in     (mux_in),
    .frame_cs_n (frame_cs_n),
    .frame_sclk (frame_sclk),
    .frame_sdo  (frame_sdo),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [11:0] chan_val [5];
  bit          scramble = 1'b0;
  int          ch = 0;          // channel the next frame must carry

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          cycles;
    int          ndone;
    bit          done_last;
  } frame_t;

  frame_t fq[$];

  // Upstream registered mux: reading of the selected channel appears one
  // cycle after select moves. In scramble mode it produces garbage whenever
  // a frame is on the wire.
  initial begin
    mux_in = '0;
    forever begin
      @(negedge clk);
      if (scramble && frame_cs_n === 1'b0) mux_in = 12'($urandom);
      else if (select < 3'd5)              mux_in = chan_val[select];
      else                                 mux_in = '0;
    end
  end

  // Wire monitor: decodes one frame per chip-select window, sampling sdo on
  // each rising sclk, and records its length and frame_done position.
  initial begin
    frame_t f;
    bit     active;
    logic   prev_sclk;
    active    = 1'b0;
    prev_sclk = 1'b0;
    f = '{word: '0, nbits: 0, cycles: 0, ndone: 0, done_last: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (frame_cs_n === 1'b0) begin
        if (!active) begin
          active    = 1'b1;
          prev_sclk = 1'b0;
          f = '{word: '0, nbits: 0, cycles: 0, ndone: 0, done_last: 1'b0};
        end
        f.cycles++;
        if (frame_sclk === 1'b1 && prev_sclk === 1'b0) begin
          f.word = {f.word[14:0], frame_sdo};
          f.nbits++;
        end
        prev_sclk = frame_sclk;
        if (frame_done === 1'b1) begin
          f.ndone++;
          f.done_last = (f.cycles == FRAME_CYC);
        end
      end else if (active) begin
        active = 1'b0;
        fq.push_back(f);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic randomize_channels();
    for (int i = 0; i < 5; i++) chan_val[i] = 12'($urandom);
  endtask

  task automatic wait_cs_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (frame_cs_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pops the next decoded frame and compares it against channel exp_ch.
  task automatic pop_frame(input int exp_ch, input string tag);
    frame_t      f;
    bit          got;
    logic [15:0] exp;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      if (fq.size() > 0) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    total++;
    if (!got) begin
      $display("FAIL %s frame_present: no frame seen, required one", tag);
    end else begin
      passed++;
      f   = fq.pop_front();
      exp = {1'b1, 3'(exp_ch), chan_val[exp_ch]};
      total++;
      if (f.word !== exp || f.nbits != 16)
        $display("FAIL %s frame_word: got %h (%0d bits), required %h (16 bits)",
                 tag, f.word, f.nbits, exp);
      else passed++;
      total++;
      if (f.cycles != FRAME_CYC)
        $display("FAIL %s frame_length: got %0d cycles, required %0d", tag, f.cycles, FRAME_CYC);
      else passed++;
      total++;
      if (f.ndone != 1 || !f.done_last)
        $display("FAIL %s frame_done: got %0d pulses (on last cycle=%0b), required 1 on last cycle",
                 tag, f.ndone, f.done_last);
      else passed++;
    end
  endtask

  // One complete frame: hold level h is applied while this frame is sent and
  // therefore decides the channel of the following frame.
  task automatic next_frame(input bit h, input string tag);
    bit ok;
    wait_cs_low(ok);
    total++;
    if (!ok) $display("FAIL %s cs_fall: got no chip-select, required one", tag);
    else passed++;
    total++;
    if (select !== 3'(ch)) $display("FAIL %s select: got %0d, required %0d", tag, select, ch);
    else passed++;
    hold = h;
    pop_frame(ch, tag);
    if (enable && !h) ch = (ch + 1) % 5;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    hold   = 1'b0;
    randomize_channels();
    repeat (3) @(posedge clk);
    #1;
    total++; if (frame_cs_n !== 1'b1) $display("FAIL reset cs_n: got %b, required 1", frame_cs_n); else passed++;
    total++; if (frame_sclk !== 1'b0) $display("FAIL reset sclk: got %b, required 0", frame_sclk); else passed++;
    total++; if (frame_sdo  !== 1'b0) $display("FAIL reset sdo: got %b, required 0", frame_sdo); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset done: got %b, required 0", frame_done); else passed++;
    total++; if (busy       !== 1'b0) $display("FAIL reset busy: got %b, required 0", busy); else passed++;
    total++; if (select     !== 3'd0) $display("FAIL reset select: got %0d, required 0", select); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL idle busy: got %b, required 0", busy); else passed++;
    total++; if (frame_cs_n !== 1'b1) $display("FAIL idle cs_n: got %b, required 1", frame_cs_n); else passed++;
    ch = 0;
  endtask

  // Cycle 0 is the first rising edge that sees enable high.
  task automatic test_first_frame_timing();
    chan_val[0] = 12'hA5C;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c <= 67; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        total++; if (busy !== 1'b1) $display("FAIL timing busy@0: got %b, required 1", busy); else passed++;
      end
      if (c == 2) begin
        total++; if (frame_cs_n !== 1'b1) $display("FAIL timing cs_n@2: got %b, required 1", frame_cs_n); else passed++;
      end
      if (c == 3) begin
        total++; if (frame_cs_n !== 1'b0) $display("FAIL timing cs_n@3: got %b, required 0", frame_cs_n); else passed++;
        total++; if (frame_sclk !== 1'b0) $display("FAIL timing sclk@3: got %b, required 0", frame_sclk); else passed++;
      end
      if (c == 5) begin
        total++; if (frame_sclk !== 1'b1) $display("FAIL timing sclk@5: got %b, required 1", frame_sclk); else passed++;
      end
      if (c == 65) begin
        total++; if (frame_done !== 1'b0) $display("FAIL timing done@65: got %b, required 0", frame_done); else passed++;
      end
      if (c == 66) begin
        total++; if (frame_done !== 1'b1) $display("FAIL timing done@66: got %b, required 1", frame_done); else passed++;
      end
      if (c == 67) begin
        total++; if (frame_done !== 1'b0) $display("FAIL timing done@67: got %b, required 0", frame_done); else passed++;
        total++;
        if (frame_cs_n !== 1'b1 || frame_sclk !== 1'b0 || frame_sdo !== 1'b0)
          $display("FAIL timing exit@67: got cs_n=%b sclk=%b sdo=%b, required 1/0/0",
                   frame_cs_n, frame_sclk, frame_sdo);
        else passed++;
      end
    end
    pop_frame(0, "timing");
    ch = 1;
  endtask

  task automatic test_rotation();
    randomize_channels();
    for (int i = 0; i < 6; i++) next_frame(1'b0, "rotation");
  endtask

  task automatic test_hold();
    bit pattern [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) next_frame(pattern[i], "hold");
  endtask

  task automatic test_random_hold();
    randomize_channels();
    for (int i = 0; i < 8; i++) next_frame(1'($urandom_range(0, 1)), "rand_hold");
    hold = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int lows;
    hold = 1'b0;
    wait_cs_low(ok);
    total++; if (!ok) $display("FAIL drop cs_fall: got no chip-select, required one"); else passed++;
    repeat (5 * BIT_CYC) @(posedge clk);
    #1;
    enable = 1'b0;
    pop_frame(ch, "drop");
    repeat (DWELL_CYC + 2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL drop busy: got %b, required 0", busy); else passed++;
    total++; if (select !== 3'(ch)) $display("FAIL drop select: got %0d, required %0d", select, ch); else passed++;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (frame_cs_n !== 1'b1) lows++;
    end
    total++; if (lows != 0) $display("FAIL drop quiet: got %0d cs_n-low cycles, required 0", lows); else passed++;
    @(negedge clk);
    enable = 1'b1;
    next_frame(1'b0, "drop_resume");
  endtask

  task automatic test_scramble();
    scramble = 1'b1;
    for (int i = 0; i < 3; i++) next_frame(1'b0, "scramble");
    scramble = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    wait_cs_low(ok);
    total++; if (!ok) $display("FAIL midrst cs_fall: got no chip-select, required one"); else passed++;
    repeat (8 * BIT_CYC) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (frame_cs_n !== 1'b1 || frame_sclk !== 1'b0 || frame_sdo !== 1'b0)
      $display("FAIL midrst outputs: got cs_n=%b sclk=%b sdo=%b, required 1/0/0",
               frame_cs_n, frame_sclk, frame_sdo);
    else passed++;
    total++; if (select !== 3'd0) $display("FAIL midrst select: got %0d, required 0", select); else passed++;
    total++; if (busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL midrst busy_done: got busy=%b done=%b, required 0/0", busy, frame_done);
    else passed++;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ch = 0;
    @(negedge clk);
    enable = 1'b1;
    next_frame(1'b0, "midrst_resume");
  endtask

  initial begin
    test_reset();
    test_first_frame_timing();
    test_rotation();
    test_hold();
    test_random_hold();
    test_enable_drop();
    test_scramble();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/solar_display_scanner.md
SOLAR_DISPLAY_SCANNER -- requirements
Module: solar_display_scanner

Interface
REQ-001 Parameter SCLK_DIV, default 2: half-period of frame_sclk in clk cycles; legal range 1-255.
REQ-002 Parameter DWELL, default 1000: idle clk cycles between frames; legal range 1-65535.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port enable  input  1  level; scanning runs while high.
REQ-006 Port hold  input  1  level; when high, the channel does not advance after dwell.
REQ-007 Port select  output  3  channel select to the upstream 5-to-1 display mux; 0=voltage, 1=current, 2=power, 3=temperature, 4=efficiency.
REQ-008 Port mux_in  input  12  registered mux output; valid 1 cycle after select changes.
REQ-009 Port frame_cs_n  output  1  serial frame chip-select, active low.
REQ-010 Port frame_sclk  output  1  serial clock.
REQ-011 Port frame_sdo  output  1  serial data, MSB first.
REQ-012 Port frame_done  output  1  one-cycle pulse at end of each frame.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CAPTURE, SHIFT and DWELL.
REQ-015 IDLE -> SETTLE when enable=1; otherwise remain in IDLE.
REQ-016 SETTLE SHALL last exactly 2 cycles (mux register latency plus 1 margin), then -> CAPTURE.
REQ-017 CAPTURE SHALL last 1 cycle, latch frame = {1'b1, select[2:0], mux_in[11:0]} (16 bits), then -> SHIFT.
REQ-018 SHIFT SHALL drive frame_cs_n=0 and emit 16 bits MSB first, each bit lasting 2*SCLK_DIV cycles.
REQ-019 Within each bit, frame_sclk SHALL be 0 for the first SCLK_DIV cycles and 1 for the next SCLK_DIV cycles; frame_sdo changes only while frame_sclk=0 at bit start.
REQ-020 SHIFT SHALL therefore last exactly 32*SCLK_DIV cycles; on the final cycle, frame_done pulses for 1 cycle and the state -> DWELL.
REQ-021 On the cycle SHIFT exits, frame_cs_n SHALL return to 1, and frame_sclk and frame_sdo to 0.
REQ-022 DWELL SHALL count exactly DWELL cycles using a 16-bit counter.
REQ-023 At DWELL end, with enable=1 and hold=0: select increments, wrapping 4 -> 0, and the state -> SETTLE.
REQ-024 At DWELL end, with enable=1 and hold=1: select is unchanged and the state -> SETTLE (same channel re-sent).
REQ-025 At DWELL end, with enable=0: the state -> IDLE and select is unchanged.
REQ-026 enable deasserted during SETTLE, CAPTURE or SHIFT SHALL NOT abort the frame; the frame completes, then the block passes through DWELL as in REQ-025.
REQ-027 select SHALL change only at a DWELL exit and SHALL never take values 5-7.
REQ-028 mux_in SHALL be sampled only in CAPTURE; changes at any other time have no effect on the frame in progress.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, select=0, frame_cs_n=1, frame_sclk=0, frame_sdo=0, frame_done=0, busy=0, and clear all counters, including mid-frame.
REQ-030 After rst_n rises, the first frame SHALL be on channel 0.

Verification
REQ-031 With SCLK_DIV=2, enable rises at cycle 0 and mux_in=12'hA5C: cs_n falls at cycle 3, the shifted word is 16'h8A5C over 64 cycles, and frame_done pulses at cycle 66.
REQ-032 With DWELL=4, hold=0, run 6 frames: select sequence is 0,1,2,3,4,0 and each frame's bits [14:12] match its select value.
REQ-033 Assert hold=1 during frame 2 (select=1): all subsequent frames carry channel 1 until hold=0, then the next frame carries channel 2.
REQ-034 Drop enable at bit 5 of SHIFT: all 16 bits complete, DWELL runs, the block enters IDLE with busy=0, and no further cs_n activity occurs.
REQ-035 Pulse rst_n low at bit 8 of SHIFT: within the same cycle cs_n=1, sclk=0, sdo=0 and select=0; after release plus enable, a full frame on channel 0 is produced.
REQ-036 Change mux_in every cycle during SHIFT: the serialized value equals the value latched in CAPTURE.
